// File: rtl/instruction_encoder_if.sv
// Handshake bus between an instruction field source and the encoder.
// The source drives the fields and out_ready; the encoder drives the emitted word.
interface instruction_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [63:0] out_addr;

    modport master (
        output in_valid, opcode, funct3, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, instruction, out_addr
    );

    modport slave (
        input  in_valid, opcode, funct3, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, instruction, out_addr
    );
endinterface

// File: rtl/instruction_encoder.sv
// Packs opcode/funct3/register/immediate fields into an RV64 I, S or SB word
// and tags each emitted word with a sequential byte address.
module instruction_encoder #(
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter int unsigned ERR_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    instruction_encoder_if.slave  bus,
    output logic                  range_err,
    output logic [ERR_W-1:0]      err_count
);
    typedef enum logic [1:0] {
        FMT_I  = 2'd0,
        FMT_S  = 2'd1,
        FMT_SB = 2'd2
    } fmt_e;

    function automatic fmt_e select_fmt(input logic [6:0] op);
        fmt_e f;
        if (op[6]) begin
            f = FMT_SB;
        end else if (op[5]) begin
            f = FMT_S;
        end else begin
            f = FMT_I;
        end
        return f;
    endfunction

    // Only immediates that survive a 12-bit sign-extending round trip are legal.
    function automatic logic imm_in_range(input logic [63:0] v);
        return (&v[63:11]) || (~|v[63:11]);
    endfunction

    function automatic logic [31:0] encode(
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [4:0]  rd_f,
        input logic [4:0]  rs1_f,
        input logic [4:0]  rs2_f,
        input logic [63:0] v
    );
        logic [31:0] w;
        case (select_fmt(op))
            FMT_SB:  w = {v[11], v[9:4], rs2_f, rs1_f, f3, v[3:0], v[10], op};
            FMT_S:   w = {v[11:5], rs2_f, rs1_f, f3, v[4:0], op};
            FMT_I:   w = {v[11:0], rs1_f, f3, rd_f, op};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    logic             out_valid_r, out_valid_s;
    logic [31:0]      instruction_r, instruction_s;
    logic [63:0]      out_addr_r, out_addr_s;
    logic [63:0]      next_addr_r, next_addr_s;
    logic             range_err_r, range_err_s;
    logic [ERR_W-1:0] err_count_r, err_count_s;
    logic             in_ready_s, in_xfer_s, out_xfer_s, in_ok_s;

    // Handshake qualification for this cycle.
    always_comb begin
        in_ready_s = !out_valid_r || bus.out_ready;
        in_xfer_s  = bus.in_valid && in_ready_s;
        out_xfer_s = out_valid_r && bus.out_ready;
        in_ok_s    = imm_in_range(bus.imm);
    end

    // Next-state computation for the output word, address counter and error tracking.
    always_comb begin
        out_valid_s   = out_valid_r;
        instruction_s = instruction_r;
        out_addr_s    = out_addr_r;
        next_addr_s   = next_addr_r;
        err_count_s   = err_count_r;
        range_err_s   = in_xfer_s && !in_ok_s;
        if (in_xfer_s && in_ok_s) begin
            out_valid_s   = 1'b1;
            instruction_s = encode(bus.opcode, bus.funct3, bus.rd, bus.rs1, bus.rs2, bus.imm);
            out_addr_s    = next_addr_r;
            next_addr_s   = next_addr_r + 64'd4;
        end else if (in_xfer_s) begin
            // Dropped input: nothing emitted, but a departing word still clears valid.
            if (out_xfer_s) begin
                out_valid_s = 1'b0;
            end else begin
                out_valid_s = out_valid_r;
            end
            if (err_count_r != {ERR_W{1'b1}}) begin
                err_count_s = err_count_r + ERR_W'(1'b1);
            end else begin
                err_count_s = err_count_r;
            end
        end else if (out_xfer_s) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r   <= 1'b0;
            instruction_r <= 32'd0;
            out_addr_r    <= BASE_ADDR;
            next_addr_r   <= BASE_ADDR;
            range_err_r   <= 1'b0;
            err_count_r   <= {ERR_W{1'b0}};
        end else begin
            out_valid_r   <= out_valid_s;
            instruction_r <= instruction_s;
            out_addr_r    <= out_addr_s;
            next_addr_r   <= next_addr_s;
            range_err_r   <= range_err_s;
            err_count_r   <= err_count_s;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.instruction = instruction_r;
    assign bus.out_addr    = out_addr_r;
    assign range_err       = range_err_r;
    assign err_count       = err_count_r;
endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: a negedge reference model predicts
// handshake, range errors and emitted words; directed phases cover the listed cases.
module tb_instruction_encoder;
    localparam logic [63:0] B0 = 64'h0000_0000_0000_1000;
    localparam logic [63:0] B1 = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk;
    logic reset;
    logic       range_err0, range_err1;
    logic [7:0] err_count0;
    logic [3:0] err_count1;

    instruction_encoder_if bus0();
    instruction_encoder_if bus1();

    instruction_encoder #(.BASE_ADDR(B0), .ERR_W(8)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .range_err(range_err0), .err_count(err_count0)
    );
    instruction_encoder #(.BASE_ADDR(B1), .ERR_W(4)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .range_err(range_err1), .err_count(err_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_enc(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [4:0] rd_v, input logic [4:0] rs1_v,
                                              input logic [4:0] rs2_v, input logic [63:0] v);
        logic [31:0] w;
        w = 32'd0;
        w[6:0]   = op;
        w[14:12] = f3;
        w[19:15] = rs1_v;
        if (op[6]) begin
            w[7]     = v[10];
            w[11:8]  = v[3:0];
            w[24:20] = rs2_v;
            w[30:25] = v[9:4];
            w[31]    = v[11];
        end else if (op[5]) begin
            w[11:7]  = v[4:0];
            w[24:20] = rs2_v;
            w[31:25] = v[11:5];
        end else begin
            w[11:7]  = rd_v;
            w[31:20] = v[11:0];
        end
        return w;
    endfunction

    function automatic logic model_ok(input logic [63:0] v);
        return ($signed(v) >= -64'sd2048) && ($signed(v) <= 64'sd2047);
    endfunction

    function automatic logic [63:0] sb_extract(input logic [31:0] w);
        logic [11:0] f;
        f = {w[31], w[7], w[30:25], w[11:8]};
        return {{52{f[11]}}, f};
    endfunction

    // Reference model and scoreboard, evaluated on the falling edge.
    logic [95:0] sb[$];
    logic        m_valid, m_rerr;
    logic [63:0] m_next;
    logic [7:0]  m_err;
    logic        mon_rdy, mon_in_x, mon_out_x;
    logic [95:0] mon_e;

    always @(negedge clk) begin
        if (reset) begin
            m_valid = 1'b0;
            m_rerr  = 1'b0;
            m_next  = B0;
            m_err   = 8'd0;
            sb.delete();
        end else begin
            mon_rdy = !m_valid || bus0.out_ready;
            check_eq("out_valid", bus0.out_valid, m_valid);
            check_eq("in_ready", bus0.in_ready, mon_rdy);
            check_eq("range_err", range_err0, m_rerr);
            check_eq("err_count", err_count0, m_err);
            mon_out_x = m_valid && bus0.out_ready;
            if (mon_out_x) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", sb.size(), 1);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("sb_instruction", bus0.instruction, mon_e[95:64]);
                    check_eq("sb_out_addr", bus0.out_addr, mon_e[63:0]);
                end
            end
            mon_in_x = bus0.in_valid && mon_rdy;
            m_rerr   = mon_in_x && !model_ok(bus0.imm);
            if (mon_in_x && model_ok(bus0.imm)) begin
                sb.push_back({model_enc(bus0.opcode, bus0.funct3, bus0.rd, bus0.rs1, bus0.rs2, bus0.imm), m_next});
                m_next  = m_next + 64'd4;
                m_valid = 1'b1;
            end else if (mon_in_x) begin
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
                if (mon_out_x) m_valid = 1'b0;
            end else if (mon_out_x) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 just after the input transfer edge.
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd_v,
                        input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic [63:0] v);
        logic got;
        bus0.in_valid = 1'b1;
        bus0.opcode   = op;
        bus0.funct3   = f3;
        bus0.rd       = rd_v;
        bus0.rs1      = rs1_v;
        bus0.rs2      = rs2_v;
        bus0.imm      = v;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bus0.in_ready;
            step();
        end
        bus0.in_valid = 1'b0;
        check_eq("send_accept", got, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    logic rnd_done;
    logic [63:0] rimm;
    int t;

    initial begin
        reset = 1'b1;
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
        bus0.opcode = 7'd0; bus0.funct3 = 3'd0; bus0.rd = 5'd0;
        bus0.rs1 = 5'd0; bus0.rs2 = 5'd0; bus0.imm = 64'd0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
        bus1.opcode = 7'd0; bus1.funct3 = 3'd0; bus1.rd = 5'd0;
        bus1.rs1 = 5'd0; bus1.rs2 = 5'd0; bus1.imm = 64'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values
        @(negedge clk);
        check_eq("rst_out_valid", bus0.out_valid, 1'b0);
        check_eq("rst_instruction", bus0.instruction, 32'd0);
        check_eq("rst_out_addr", bus0.out_addr, B0);
        check_eq("rst_in_ready", bus0.in_ready, 1'b1);
        check_eq("rst_err_count", err_count0, 8'd0);
        step();

        // I-type, held under backpressure to observe one-cycle latency
        bus0.out_ready = 1'b0;
        send(7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        check_eq("i_valid", bus0.out_valid, 1'b1);
        check_eq("i_word", bus0.instruction, 32'hFFF30293);
        check_eq("i_addr", bus0.out_addr, B0);
        step();
        bus0.out_ready = 1'b1;

        // S-type
        send(7'h23, 3'd3, 5'd0, 5'd2, 5'd8, 64'd16);
        @(negedge clk);
        check_eq("s_word", bus0.instruction, 32'h00813823);
        check_eq("s_addr", bus0.out_addr, B0 + 64'd4);
        step();

        // SB-type and round trip through immediate extraction
        send(7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        check_eq("sb_word", bus0.instruction, 32'hFE208EE3);
        check_eq("sb_roundtrip", sb_extract(bus0.instruction), 64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("sb_addr", bus0.out_addr, B0 + 64'd8);
        step();

        // Range error then a valid word taking the unused address
        send(7'h13, 3'd0, 5'd1, 5'd1, 5'd0, 64'h800);
        @(negedge clk);
        check_eq("rerr_pulse", range_err0, 1'b1);
        check_eq("rerr_count", err_count0, 8'd1);
        check_eq("rerr_no_out", bus0.out_valid, 1'b0);
        step();
        @(negedge clk);
        check_eq("rerr_cleared", range_err0, 1'b0);
        step();
        send(7'h13, 3'd1, 5'd3, 5'd4, 5'd0, 64'd7);
        @(negedge clk);
        check_eq("rerr_next_addr", bus0.out_addr, B0 + 64'd12);
        step();

        // Backpressure: three words, four stalled cycles, then consecutive transfers
        bus0.out_ready = 1'b0;
        fork
            begin
                send(7'h13, 3'd2, 5'd10, 5'd11, 5'd0, 64'd100);
                send(7'h23, 3'd2, 5'd0, 5'd12, 5'd13, 64'hFFFF_FFFF_FFFF_FF00);
                send(7'h63, 3'd1, 5'd0, 5'd14, 5'd15, 64'd2046);
            end
            begin
                step();
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check_eq("bp_in_ready", bus0.in_ready, 1'b0);
                    check_eq("bp_hold_word", bus0.instruction, model_enc(7'h13, 3'd2, 5'd10, 5'd11, 5'd0, 64'd100));
                    check_eq("bp_hold_addr", bus0.out_addr, B0 + 64'd16);
                    step();
                end
                bus0.out_ready = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check_eq("bp_xfer", bus0.out_valid && bus0.out_ready, 1'b1);
                    check_eq("bp_addr", bus0.out_addr, B0 + 64'd16 + 64'(4 * i));
                    step();
                end
            end
        join

        // Random fields, immediates around the range limits, random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    case ($urandom_range(0, 5))
                        0: begin t = int'($urandom_range(0, 4095)) - 2048; rimm = 64'(t); end
                        1: rimm = 64'h0000_0000_0000_07FF;
                        2: rimm = 64'hFFFF_FFFF_FFFF_F800;
                        3: rimm = 64'h0000_0000_0000_0800;
                        4: rimm = 64'hFFFF_FFFF_FFFF_F7FF;
                        default: rimm = {$urandom, $urandom};
                    endcase
                    send(7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rimm);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    bus0.out_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        bus0.out_ready = 1'b1;
        repeat (3) step();

        // Reset while a word is held overrides a same-cycle transfer
        bus0.out_ready = 1'b0;
        send(7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 64'd5);
        reset = 1'b1;
        bus0.out_ready = 1'b1;
        bus0.in_valid = 1'b1;
        step();
        reset = 1'b0;
        bus0.in_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", bus0.out_valid, 1'b0);
        check_eq("mid_rst_addr", bus0.out_addr, B0);
        check_eq("mid_rst_word", bus0.instruction, 32'd0);
        step();

        // Error counter saturation
        for (int n = 0; n < 260; n++) begin
            send(7'h13, 3'd0, 5'd1, 5'd1, 5'd0, 64'h800);
        end
        @(negedge clk);
        check_eq("sat_count", err_count0, 8'd255);
        step();

        // Address wrap on the second instance
        bus1.opcode = 7'h13; bus1.funct3 = 3'd0; bus1.rd = 5'd1;
        bus1.rs1 = 5'd2; bus1.imm = 64'd1;
        bus1.in_valid = 1'b1;
        step();
        @(negedge clk);
        check_eq("wrap_first_addr", bus1.out_addr, B1);
        check_eq("wrap_word", bus1.instruction, model_enc(7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 64'd1));
        step();
        bus1.in_valid = 1'b0;
        @(negedge clk);
        check_eq("wrap_second_valid", bus1.out_valid, 1'b1);
        check_eq("wrap_second_addr", bus1.out_addr, 64'd0);
        check_eq("wrap_no_err", {range_err1, err_count1}, 5'd0);
        step();

        repeat (2) step();
        check_eq("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs decoded instruction fields (opcode, funct3, register indices, 64-bit immediate) back into a 32-bit RV64 I/S/SB instruction word. It is the inverse of the immediate extraction logic: for every accepted, in-range input, extracting the immediate from `instruction` returns `imm` exactly. It sits between a test or program generator and the instruction memory write port. It uses a valid/ready handshake on both sides and assigns sequential byte addresses to the instructions it emits.

## Interface
Parameters:
- `BASE_ADDR`, default `64'd0`: byte address assigned to the first emitted instruction after reset.
- `ERR_W`, default `8`: width of the saturating error counter.

Ports:
- `clk`  input  1  clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  input fields are valid.
- `in_ready`  output  1  encoder can accept this cycle.
- `opcode`  input  7  opcode; also selects the format.
- `funct3`  input  3  funct3 field.
- `rd`  input  5  destination register; used for I-type only.
- `rs1`  input  5  source register 1.
- `rs2`  input  5  source register 2; used for S/SB only.
- `imm`  input  64  immediate value, sign-extended form.
- `out_valid`  output  1  `instruction` and `out_addr` are valid.
- `out_ready`  input  1  downstream accepts this cycle.
- `instruction`  output  32  encoded word.
- `out_addr`  output  64  byte address of `instruction`.
- `range_err`  output  1  one-cycle pulse: the last accepted input was dropped.
- `err_count`  output  ERR_W  number of dropped inputs; saturates at all-ones.

## Operation
**Format selection**
- `opcode[6]=1` selects SB.
- Otherwise `opcode[5]=1` selects S.
- Otherwise I.

**Range check** (all formats): `imm[63:11]` must be all zeros or all ones.

**Encoding**
- I: {imm[11:0], rs1, funct3, rd, opcode}
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
- SB: {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode}
- The SB immediate is the unshifted 12-bit field value; it is not a byte offset.

**Handshake**
- Input transfer occurs when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational and allows one transfer per cycle.
- Output transfer occurs when `out_valid && out_ready`.

**Accepted in-range input** (next edge)
- `instruction` takes the encoded word.
- `out_addr` takes `next_addr`.
- `next_addr` advances by 4, modulo 2^64; wrap-around is silent.
- `out_valid` goes to 1.

**Accepted out-of-range input** (next edge)
- Nothing is emitted.
- `range_err` is 1 for exactly one cycle.
- `err_count` increments, holding at all-ones once saturated.
- `next_addr` is unchanged.
- `out_valid` goes to 0 if the old word transferred this cycle; otherwise it holds.

**Other cycles**
- No input transfer but an output transfer: `out_valid` goes to 0.
- Neither transfer: all outputs hold. `instruction` and `out_addr` stay stable while `out_valid && !out_ready`.
- Input transfer and output transfer in the same cycle: the old word leaves and the new word loads, so there is no bubble.

## Timing
- **Reset values:**
  - `out_valid=0`, `instruction=0`, `out_addr=BASE_ADDR`.
  - Internal `next_addr=BASE_ADDR`.
  - `range_err=0`, `err_count=0`.
  - `in_ready=1` in the cycle after reset deasserts.
- **Reset mid-operation:** a held, untransferred word is discarded and `reset` overrides any same-cycle transfer.
- **Latency:** one cycle from input transfer to `out_valid`.
- **Throughput:** one instruction per cycle when `out_ready` is held at 1.
- Output `instruction` is registered, with no combinational path from the field inputs.
- `range_err` is asserted in the cycle after the offending transfer and cleared the cycle after that, regardless of `out_ready`.

## Test plan
- **I-type:** opcode=0x13, funct3=0, rd=5, rs1=6, imm=64'hFFFF_FFFF_FFFF_FFFF.
  - Required: instruction=0xFFF30293, out_addr=BASE_ADDR, 1-cycle latency.
- **S-type:** opcode=0x23, funct3=3, rs1=2, rs2=8, imm=16.
  - Required: instruction=0x00813823, out_addr=BASE_ADDR+4 when sent after the I-type case.
- **SB-type:** opcode=0x63, funct3=0, rs1=1, rs2=2, imm=64'hFFFF_FFFF_FFFF_FFFE.
  - Required: instruction=0xFE208EE3.
  - Required: immediate extraction of the result yields the same 64-bit imm.
- **Range error:** I-type with imm=0x800, then a valid I-type.
  - Required: no output for the first input, range_err pulse of 1 cycle, err_count=1.
  - Required: the second word's out_addr equals the address that would have been assigned to the dropped input.
- **Backpressure and reset:**
  - Stream 3 words with `out_ready=0` for 4 cycles: outputs stay stable, in_ready=0, then 3 transfers occur on consecutive cycles with addresses +0/+4/+8.
  - Assert `reset` while out_valid=1: next cycle out_valid=0 and out_addr=BASE_ADDR.
- **Saturation and wrap:**
  - 260 out-of-range inputs with ERR_W=8: err_count stops at 255.
  - BASE_ADDR=64'hFFFF_FFFF_FFFF_FFFC: second word's out_addr=0.
